// File: rtl/fwperiph_dma_dbg_trace.sv
// Write-trace capture: filters debug writes by address, stores {adr, dat, ts}
// into a circular buffer and presents the oldest event first-word-fall-through.
module fwperiph_dma_dbg_trace #(
  parameter int          depth_log2 = 4,
  parameter int          ts_width   = 16,
  parameter logic [31:0] adr_base   = 32'h0000_0000,
  parameter logic [31:0] adr_mask   = 32'hFFFF_F000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           adr,
  input  logic [31:0]           dat_w,
  input  logic [31:0]           we,
  input  logic                  enable,
  input  logic                  stop_on_full,
  input  logic                  clear,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [31:0]           ev_adr,
  output logic [31:0]           ev_dat,
  output logic [ts_width-1:0]   ev_ts,
  output logic [depth_log2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [15:0]           overflow_cnt,
  output logic                  stopped
);

  localparam int DEPTH = 1 << depth_log2;
  localparam logic [depth_log2:0] DEPTH_C = (depth_log2+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]         adr;
    logic [31:0]         dat;
    logic [ts_width-1:0] ts;
  } ev_t;

  typedef enum logic {RUN, STOPPED} state_t;

  state_t                state_q, state_d;
  ev_t                   mem [DEPTH];
  logic [depth_log2-1:0] wr_ptr, rd_ptr;
  logic [ts_width-1:0]   ts_cnt;
  logic                  hit, pop, push, drop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign ev_valid = !empty;
  assign stopped  = (state_q == STOPPED);

  assign hit  = enable && (we != '0) && ((adr & adr_mask) == (adr_base & adr_mask))
                && (state_q == RUN);
  assign pop  = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot the push needs, so full only drops without one.
  assign push = hit && (!full || pop);
  assign drop = hit && full && !pop;

  assign ev_adr = mem[rd_ptr].adr;
  assign ev_dat = mem[rd_ptr].dat;
  assign ev_ts  = mem[rd_ptr].ts;

  // Next state: freeze on the first drop when stop_on_full is set; only clear/reset leave STOPPED.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && drop && stop_on_full) state_d = STOPPED;
  end

  // Control state: FSM, pointers, occupancy, overflow and timestamp counters.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_q      <= RUN;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
      ts_cnt       <= '0;
    end else begin
      state_q <= state_d;
      ts_cnt  <= ts_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  // Event storage; no reset needed since ev_valid gates visibility.
  always_ff @(posedge clock) begin
    if (!reset && !clear && push) mem[wr_ptr] <= '{adr: adr, dat: dat_w, ts: ts_cnt};
  end

endmodule

// File: tb/tb_fwperiph_dma_dbg_trace.sv
// Directed bench for the write-trace capture stage.
module tb_fwperiph_dma_dbg_trace;
  logic        clock = 1'b0;
  logic        reset, enable, stop_on_full, clear, ev_ready;
  logic [31:0] adr, dat_w, we;
  logic        ev_valid, full, empty, stopped;
  logic [31:0] ev_adr, ev_dat;
  logic [15:0] ev_ts, overflow_cnt;
  logic [4:0]  count;

  int vectors = 0;
  int errors  = 0;

  fwperiph_dma_dbg_trace dut (
    .clock(clock), .reset(reset), .adr(adr), .dat_w(dat_w), .we(we),
    .enable(enable), .stop_on_full(stop_on_full), .clear(clear),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_adr(ev_adr), .ev_dat(ev_dat),
    .ev_ts(ev_ts), .count(count), .full(full), .empty(empty),
    .overflow_cnt(overflow_cnt), .stopped(stopped)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adr = a; dat_w = d; we = 32'd1;
  endtask

  task automatic idle();
    we = 32'd0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; stop_on_full = 1'b0; clear = 1'b0; ev_ready = 1'b0;
    adr = '0; dat_w = '0; we = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_valid", ev_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_stopped", stopped, 0);
    chk("rst_ovf", overflow_cnt, 0);

    // 1: single capture at ts=5 (cycle after reset release holds ts=0)
    enable = 1'b1;
    repeat (5) step();
    wr(32'h10, 32'hA5A5_0001);
    step();
    idle();
    chk("t1_valid", ev_valid, 1);
    chk("t1_adr", ev_adr, 32'h10);
    chk("t1_dat", ev_dat, 32'hA5A5_0001);
    chk("t1_ts", ev_ts, 5);
    chk("t1_count", count, 1);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    chk("t1_drained", empty, 1);

    // 2: address filter and we=0
    wr(32'h0000_1004, 32'h1); step();
    adr = 32'h8; dat_w = 32'h2; we = 32'd0; step();
    chk("t2_count", count, 0);
    chk("t2_ovf", overflow_cnt, 0);

    // 3: overflow without freeze
    for (int i = 0; i < 20; i++) begin wr(32'h20, i); step(); end
    idle();
    chk("t3_full", full, 1);
    chk("t3_count", count, 16);
    chk("t3_ovf", overflow_cnt, 4);
    chk("t3_stopped", stopped, 0);
    ev_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin chk("t3_drain", ev_dat, i); step(); end
    ev_ready = 1'b0;
    chk("t3_empty", empty, 1);

    // 4: overflow with freeze
    clear = 1'b1; step(); clear = 1'b0;
    chk("t4_clr_ovf", overflow_cnt, 0);
    stop_on_full = 1'b1;
    for (int i = 0; i < 17; i++) begin wr(32'h30, 100 + i); step(); end
    chk("t4_stopped", stopped, 1);
    chk("t4_ovf17", overflow_cnt, 1);
    wr(32'h30, 117); step();
    chk("t4_ovf18", overflow_cnt, 1);
    chk("t4_count", count, 16);
    ev_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain", ev_dat, 100 + i);
      wr(32'h30, 500 + i); step();
    end
    ev_ready = 1'b0;
    wr(32'h30, 600); step(); idle();
    chk("t4_ignored", empty, 1);
    chk("t4_still_stop", stopped, 1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("t4_clr_stop", stopped, 0);
    chk("t4_clr_ovf2", overflow_cnt, 0);
    chk("t4_clr_empty", empty, 1);
    wr(32'h40, 32'h77); step(); idle();
    chk("t4_resume_cnt", count, 1);
    chk("t4_resume_dat", ev_dat, 32'h77);

    // 5: push+pop when full, 40 cycles with wrap
    clear = 1'b1; step(); clear = 1'b0;
    stop_on_full = 1'b0;
    for (int i = 0; i < 16; i++) begin wr(32'h50, 200 + i); step(); end
    chk("t5_full", full, 1);
    ev_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      chk("t5_order", ev_dat, 200 + k);
      wr(32'h50, 216 + k); step();
      chk("t5_count", count, 16);
    end
    idle();
    chk("t5_ovf", overflow_cnt, 0);
    for (int i = 0; i < 16; i++) begin chk("t5_tail", ev_dat, 240 + i); step(); end
    ev_ready = 1'b0;
    chk("t5_empty", empty, 1);

    // 6: clear coincident with a hit at count=3; ts restarts
    for (int i = 0; i < 3; i++) begin wr(32'h60, 300 + i); step(); end
    chk("t6_count3", count, 3);
    clear = 1'b1; wr(32'h60, 303); step(); clear = 1'b0; idle();
    chk("t6_count0", count, 0);
    chk("t6_valid0", ev_valid, 0);
    step();                        // cycle holding ts=0
    wr(32'h60, 304); step(); idle();
    chk("t6_ts", ev_ts, 1);
    chk("t6_dat", ev_dat, 304);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fwperiph_dma_dbg_trace.md
Name: fwperiph_dma_dbg_trace

Overview:
Write-trace capture stage directly downstream of the DMA debug tap. It consumes the same debug write stream (adr, dat_w, we) and records matching register writes into a circular event buffer, with a timestamp for each event. A debug host drains the buffer over a valid/ready event port. It also provides overflow accounting and an optional stop-on-full freeze.

Parameters:
depth_log2, 4, log2 of buffer depth in events (depth = 16).
ts_width, 16, width of free-running timestamp counter and of captured timestamps.
adr_base, 32'h0000_0000, address-match base.
adr_mask, 32'hFFFF_F000, bits of adr compared against adr_base.

Ports:
clock  in  1  system clock, all logic rising-edge.
reset  in  1  synchronous, active-high reset.
adr  in  32  debug write address, same stream the debug tap receives.
dat_w  in  32  debug write data.
we  in  32  debug write enable; any nonzero value is a write event.
enable  in  1  capture enable.
stop_on_full  in  1  1 = freeze capture on first dropped event.
clear  in  1  synchronous flush of buffer, counters and freeze state.
ev_valid  out  1  head event available.
ev_ready  in  1  consumer accepts head event.
ev_adr  out  32  head event address.
ev_dat  out  32  head event data.
ev_ts  out  ts_width  head event timestamp.
count  out  depth_log2+1  events currently buffered.
full  out  1  count == depth.
empty  out  1  count == 0.
overflow_cnt  out  16  dropped-event count, saturating.
stopped  out  1  FSM in STOPPED.

Behaviour:
- Reset and clear: pointers, count, overflow_cnt and ts counter are 0. FSM goes to RUN. Outputs after either: ev_valid=0, empty=1, full=0, stopped=0, overflow_cnt=0. ev_adr/ev_dat/ev_ts are don't-care while ev_valid=0.
- Priority: reset, then clear, then all other activity. Clear in the same cycle as a hit or pop discards both.
- ts counter increments by 1 every cycle and wraps modulo 2^ts_width. A captured event stores the counter value present in its hit cycle.
- hit = enable & (we != 0) & ((adr & adr_mask) == (adr_base & adr_mask)) & (state == RUN).
- pop = ev_valid & ev_ready.
- Push: on hit, {adr, dat_w, ts} is written at wr_ptr, and wr_ptr advances modulo depth.
- Push when full without a pop in the same cycle: the event is dropped and overflow_cnt increments, saturating at 16'hFFFF.
- Push when full with a pop in the same cycle: the push is accepted and count stays at depth.
- Pop advances rd_ptr modulo depth. The next entry is presented in the following cycle.
- Push and pop together with count>0: count is unchanged.
- Pop when empty is impossible because ev_valid=0.
- Output is first-word-fall-through: ev_valid = !empty, and ev_* are driven from the entry at rd_ptr.
- Latency: a hit in cycle N into an empty buffer gives ev_valid=1 in cycle N+1.
- Events leave in capture order across pointer wrap-around.
- FSM has two states, RUN and STOPPED.
  - RUN -> STOPPED when an event is dropped while stop_on_full=1.
  - STOPPED -> RUN only on clear or reset.
  - In STOPPED, no capture occurs, overflow_cnt is frozen, and popping continues normally.
- Deasserting enable suppresses capture only. It does not change the FSM state, the ts counter or popping.

Test Plan:
1. Reset, then enable=1, ev_ready=0, a single write adr=32'h0000_0010, dat_w=32'hA5A5_0001, we=1 at ts=5.
   -> next cycle ev_valid=1, ev_adr=32'h10, ev_dat=32'hA5A5_0001, ev_ts=5, count=1.
2. Address filter: write adr=32'h0000_1004 (outside the mask match), and a write with we=0 at adr=32'h8.
   -> count stays 0, overflow_cnt=0.
3. Overflow without freeze: 20 back-to-back matching writes with dat_w=0..19, ev_ready=0, stop_on_full=0.
   -> full=1, count=16, overflow_cnt=4.
   -> Drain: data 0..15 in order, then empty=1.
4. Overflow with freeze: stop_on_full=1, 18 writes.
   -> stopped=1 after the 17th write, overflow_cnt=1 (18th write ignored).
   -> Drain 16 events; further writes are ignored.
   -> clear -> stopped=0, overflow_cnt=0, capture resumes.
5. Simultaneous push and pop when full (ev_ready=1, hit in the same cycle).
   -> count stays 16, overflow_cnt unchanged.
   -> After 40 such cycles with wrap-around, the data order is preserved.
6. Clear asserted in the same cycle as a hit with count=3.
   -> next cycle count=0, ev_valid=0, ev_ts of the next capture reflects a restarted ts counter (event one cycle after clear has ts=1).
